piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits; legal values are 2 and above.
REQ-002 The block SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-low reset.
REQ-004 The block SHALL have port p_data, input, WIDTH bits, the parallel word to serialize.
REQ-005 The block SHALL have port p_valid, input, 1 bit; when high, p_data is valid.
REQ-006 The block SHALL have port p_ready, output, 1 bit; when high, the block can accept a word this cycle.
REQ-007 The block SHALL have port lsb_first, input, 1 bit, the bit-order select, sampled only on load (1 = LSB first, 0 = MSB first).
REQ-008 The block SHALL have port s_data, output, 1 bit, the current serial bit.
REQ-009 The block SHALL have port s_valid, output, 1 bit; when high, s_data is valid.
REQ-010 The block SHALL have port s_ready, input, 1 bit, sink backpressure; a beat is taken when s_valid and s_ready are both high.
REQ-011 The block SHALL have port s_last, output, 1 bit, high on the final bit of each word.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a word is being serialized.

Function
REQ-013 The block SHALL implement two states, IDLE and SHIFT.
REQ-014 p_ready SHALL be high in IDLE, or in SHIFT when s_ready and s_last are both high (a combinational path from s_ready to p_ready is permitted).
REQ-015 A load (p_valid and p_ready both high) SHALL capture p_data into the shift register, capture lsb_first into the mode register, set the bit counter to WIDTH-1 and enter SHIFT.
REQ-016 s_valid and busy SHALL equal (state == SHIFT); the first bit SHALL appear on s_data in the cycle after the load, giving a latency of 1.
REQ-017 s_data SHALL be shift_reg[WIDTH-1] in MSB-first mode and shift_reg[0] in LSB-first mode.
REQ-018 On each beat, the shift register SHALL shift by one toward the output end (left for MSB-first, right for LSB-first, zero fill) and the counter SHALL decrement.
REQ-019 s_last SHALL be high when the block is in SHIFT and the counter equals 0.
REQ-020 While s_valid is high and s_ready is low, s_data, s_last, the counter and the shift register SHALL hold.
REQ-021 When the last beat is taken, the block SHALL load the next word in the same cycle if p_valid is high (no bubble); otherwise it SHALL return to IDLE.
REQ-022 Changes on p_data, p_valid and lsb_first outside a load SHALL NOT affect the word in flight.
REQ-023 With continuous p_valid and s_ready, sustained throughput SHALL be 1 bit per cycle.
REQ-024 The counter width SHALL be $clog2(WIDTH).

Reset
REQ-025 While rst is low at a clock edge, the block SHALL set state to IDLE and clear the shift register, counter and mode register to 0.
REQ-026 During reset, s_valid, s_data, s_last and busy SHALL be 0, and p_ready SHALL be forced to 0.
REQ-027 A reset mid-word SHALL discard the word; no remaining bit of it SHALL be emitted after reset releases.
REQ-028 p_ready SHALL be high in the first cycle after rst is released.

Structure
REQ-029 Shared package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the default-width constant PISO_WIDTH_DEF = 8.
REQ-030 The bit counter SHALL be the sub-module piso_bit_counter, a down-counter with load, enable and zero flag, parametrised by WIDTH.
REQ-031 The shift register, mode register and FSM SHALL reside in piso_serializer.

Verification (WIDTH=8)
REQ-032 Bench SHALL cover: load 8'hA5, lsb_first=0, s_ready=1 -> s_data 1,0,1,0,0,1,0,1 on cycles 1-8, s_last only on cycle 8, p_ready high on cycle 8.
REQ-033 Bench SHALL cover: load 8'h0F, lsb_first=1 -> s_data 1,1,1,1,0,0,0,0, then busy=0.
REQ-034 Bench SHALL cover: 8'hA5 MSB-first with s_ready low for 3 cycles after bit 2 -> s_data held at 1, s_valid held, 8 bits total with none lost or duplicated.
REQ-035 Bench SHALL cover: p_valid held with 8'hF0 then 8'h0F, MSB-first -> 16 contiguous s_valid cycles, bits 11110000 00001111, s_last on cycles 8 and 16.
REQ-036 Bench SHALL cover: rst low after 3 bits of 8'hFF -> s_valid=0 next cycle; after release, p_ready=1, and load 8'h80 yields 1 then seven 0s.
REQ-037 Bench SHALL cover: toggling p_data and lsb_first during SHIFT -> output sequence unchanged from the loaded word and mode.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out serializer.
// Holds the FSM state encoding and the default word width.
package piso_pkg;

  localparam int PISO_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Down-counter with load, enable and zero flag.
// Load always presets to WIDTH-1, the index of the last bit of a word.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(WIDTH - 1);
    end else if (en) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready on both sides.
// Back-to-back words stream with no bubble when the next word is waiting.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_data,
  input  logic             p_valid,
  output logic             p_ready,
  input  logic             lsb_first,
  output logic             s_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             s_last,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             mode_q;
  logic             mode_d;

  logic cnt_zero;
  logic in_shift;
  logic beat;
  logic load;

  // Outputs are gated by rst so they read 0 while reset is asserted.
  assign in_shift = rst && (state_q == SHIFT);
  assign s_valid  = in_shift;
  assign busy     = in_shift;
  assign s_last   = in_shift && cnt_zero;
  assign s_data   = in_shift &&
                    (mode_q ? shift_q[0] : shift_q[WIDTH-1]);

  assign beat    = s_valid && s_ready;
  assign p_ready = rst &&
                   ((state_q == IDLE) || (s_ready && s_last));
  assign load    = p_valid && p_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    if (load) begin
      shift_d = p_data;
      mode_d  = lsb_first;
      state_d = SHIFT;
    end else if (beat) begin
      shift_d = mode_q ? (shift_q >> 1) : (shift_q << 1);
      if (cnt_zero) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
    end
  end

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (beat && !load),
    .zero (cnt_zero)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer at WIDTH=8.
// Directed vectors, corner sequences and a queue-based random model.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] p_data;
  logic       p_valid;
  logic       p_ready;
  logic       lsb_first;
  logic       s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_last;
  logic       busy;

  int total;
  int bad;

  piso_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .lsb_first (lsb_first),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       lsb;
    logic [7:0] seq;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic load_word(input logic [7:0] d,
                           input logic l);
    p_valid   = 1'b1;
    p_data    = d;
    lsb_first = l;
    #1;
    chk("load_p_ready", p_ready, 1);
    tick();
    p_valid = 1'b0;
  endtask

  vec_t vecs[5];
  logic q[$];
  logic seq16[16];
  logic got[$];

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    p_data = '0;
    p_valid = 1'b0;
    lsb_first = 1'b0;
    s_ready = 1'b1;

    vecs[0] = '{8'hA5, 1'b0, 8'b10100101};
    vecs[1] = '{8'h0F, 1'b1, 8'b11110000};
    vecs[2] = '{8'h3C, 1'b1, 8'b00111100};
    vecs[3] = '{8'h81, 1'b0, 8'b10000001};
    vecs[4] = '{8'h01, 1'b1, 8'b10000000};

    // reset state
    tick();
    tick();
    #1;
    chk("rst_s_valid", s_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p_ready", p_ready, 0);
    chk("rst_s_last", s_last, 0);
    rst = 1'b1;
    #1;
    chk("rel_p_ready", p_ready, 1);
    chk("rel_busy", busy, 0);

    // directed table
    for (int v = 0; v < 5; v++) begin
      load_word(vecs[v].data, vecs[v].lsb);
      for (int i = 0; i < 8; i++) begin
        #1;
        chk("vec_s_valid", s_valid, 1);
        chk("vec_s_data", s_data, vecs[v].seq[7-i]);
        chk("vec_s_last", s_last, i == 7);
        chk("vec_p_ready", p_ready, i == 7);
        lsb_first = ~lsb_first;
        p_data = 8'($urandom);
        tick();
      end
      #1;
      chk("vec_busy_end", busy, 0);
    end

    // stall for 3 cycles after bit 2
    load_word(8'hA5, 1'b0);
    got.delete();
    for (int k = 0; k < 20 && got.size() < 8; k++) begin
      s_ready = !(k >= 2 && k < 5);
      #1;
      if (!s_ready) begin
        chk("stall_s_valid", s_valid, 1);
        chk("stall_s_data", s_data, 1);
      end
      if (s_valid && s_ready) got.push_back(s_data);
      tick();
    end
    s_ready = 1'b1;
    chk("stall_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk("stall_bits", got[i], vecs[0].seq[7-i]);
    #1;
    chk("stall_idle", busy, 0);

    // back-to-back F0 then 0F
    for (int i = 0; i < 8; i++) seq16[i] = (i < 4);
    for (int i = 8; i < 16; i++) seq16[i] = (i >= 12);
    load_word(8'hF0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      p_valid = (i <= 7);
      p_data = 8'h0F;
      lsb_first = 1'b0;
      #1;
      chk("b2b_s_valid", s_valid, 1);
      chk("b2b_s_data", s_data, seq16[i]);
      chk("b2b_s_last", s_last, (i == 7) || (i == 15));
      if (i == 7) chk("b2b_p_ready", p_ready, 1);
      tick();
    end
    p_valid = 1'b0;
    #1;
    chk("b2b_end", s_valid, 0);

    // reset mid-word
    load_word(8'hFF, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_s_valid", s_valid, 0);
    chk("midrst_p_ready", p_ready, 0);
    tick();
    chk("midrst_held", s_valid, 0);
    rst = 1'b1;
    #1;
    chk("midrst_rel_valid", s_valid, 0);
    chk("midrst_rel_ready", p_ready, 1);
    load_word(8'h80, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("midrst_s_valid2", s_valid, 1);
      chk("midrst_s_data", s_data, i == 0);
      tick();
    end

    // inputs toggling during shift
    load_word(8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) begin
      p_data = 8'($urandom);
      lsb_first = 1'($urandom);
      p_valid = (i == 7) ? 1'b0 : 1'($urandom);
      #1;
      chk("tog_s_data", s_data, vecs[0].seq[7-i]);
      chk("tog_s_last", s_last, i == 7);
      tick();
    end
    p_valid = 1'b0;

    // random traffic against a bit-queue model
    q.delete();
    for (int c = 0; c < 600; c++) begin
      logic exp_rdy;
      p_valid = ($urandom_range(0, 3) != 0);
      p_data = 8'($urandom);
      lsb_first = 1'($urandom);
      s_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = (q.size() == 0) ||
                (s_ready && q.size() == 1);
      chk("rnd_s_valid", s_valid, q.size() != 0);
      chk("rnd_p_ready", p_ready, exp_rdy);
      if (q.size() != 0) begin
        chk("rnd_s_data", s_data, q[0]);
        chk("rnd_s_last", s_last, q.size() == 1);
      end
      if (q.size() != 0 && s_ready) void'(q.pop_front());
      if (p_valid && exp_rdy) begin
        for (int b = 0; b < 8; b++)
          q.push_back(lsb_first ? p_data[b] : p_data[7-b]);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
